// File: rtl/clock_core_adj_pkg.sv
// Shared definitions for the clock_core_adj time-of-day core.
//   - BCD digit and field widths
//   - adjust FSM state encoding and field selector encoding
//   - default field limits
//   - to_bcd(): integer (0..99) to packed two-digit BCD
package clock_core_adj_pkg;

  localparam int DIGIT_W      = 4;
  localparam int FIELD_W      = 8;

  localparam int HOUR_MAX_DEF = 23;
  localparam int MIN_MAX_DEF  = 59;
  localparam int SEC_MAX_DEF  = 59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_HOLD = 2'd2,
    ST_RPT  = 2'd3
  } adj_state_e;

  // Field codes double as indices into the per-field arrays (0 = seconds).
  typedef enum logic [1:0] {
    FLD_S    = 2'd0,
    FLD_M    = 2'd1,
    FLD_H    = 2'd2,
    FLD_NONE = 2'd3
  } field_e;

  function automatic logic [FIELD_W-1:0] to_bcd(input int unsigned v);
    logic [DIGIT_W-1:0] hi;
    logic [DIGIT_W-1:0] lo;
    hi = DIGIT_W'(v / 10);
    lo = DIGIT_W'(v % 10);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/clock_core_adj_bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter, range 00..MAX.
// Ports:
//   clk_i   clock
//   srst_i  synchronous active-high reset, clears q to 00
//   inc_i   count up (MAX -> 00)
//   dec_i   count down (00 -> MAX)
//   load_i  load d_i; an invalid digit or a value above MAX loads 00
//   d_i     packed BCD load value
//   q_o     registered packed BCD value
//   wrap_o  combinational: this cycle's increment takes q from MAX to 00
// Priority inside the counter: load > inc > dec.
module clock_core_adj_bcd_mod_counter
  import clock_core_adj_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               load_i,
  input  logic [FIELD_W-1:0] d_i,
  output logic [FIELD_W-1:0] q_o,
  output logic               wrap_o
);

  localparam logic [FIELD_W-1:0] MAX_BCD = to_bcd(MAX);

  logic [FIELD_W-1:0] q_q;
  logic [FIELD_W-1:0] q_d;
  logic [DIGIT_W-1:0] hi;
  logic [DIGIT_W-1:0] lo;
  logic               d_ok;

  always_comb begin
    q_d  = q_q;
    hi   = q_q[FIELD_W-1:DIGIT_W];
    lo   = q_q[DIGIT_W-1:0];
    // With both digits valid, packed BCD orders like the decimal value.
    d_ok = (d_i[FIELD_W-1:DIGIT_W] <= 4'd9) && (d_i[DIGIT_W-1:0] <= 4'd9) &&
           (d_i <= MAX_BCD);
    if (load_i) begin
      q_d = d_ok ? d_i : '0;
    end else if (inc_i) begin
      if (q_q == MAX_BCD)  q_d = '0;
      else if (lo == 4'd9) q_d = {hi + 4'd1, 4'd0};
      else                 q_d = {hi, lo + 4'd1};
    end else if (dec_i) begin
      if (q_q == '0)       q_d = MAX_BCD;
      else if (lo == 4'd0) q_d = {hi - 4'd1, 4'd9};
      else                 q_d = {hi, lo - 4'd1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o    = q_q;
  assign wrap_o = inc_i & ~load_i & (q_q == MAX_BCD);

endmodule

// File: rtl/clock_core_adj.sv
// BCD HH:MM:SS time-of-day core with preset and push-button adjustment.
// Ports:
//   CP              clock
//   CR              synchronous active-high reset
//   CE              count enable for time-keeping (adjust/preset still act)
//   TICK            1 Hz strobe, one CP cycle wide
//   PE, D_H/M/S     preset strobe and packed-BCD preset values
//   HU/HD MU/MD SU/SD  level buttons, up/down per field, high = pressed
//   Q_H/M/S         registered packed-BCD time
//   TC_S/M/H        one-cycle pulses when a tick/carry wraps the field
//   ADJ             high while the adjust FSM is away from IDLE
// Per-cycle priority: CR > PE > adjust step > tick. A tick that collides with
// a step is parked in a one-deep pending flag and applied on the next cycle
// without a step.
module clock_core_adj
  import clock_core_adj_pkg::*;
#(
  parameter int HOUR_MAX   = HOUR_MAX_DEF,
  parameter int MIN_MAX    = MIN_MAX_DEF,
  parameter int SEC_MAX    = SEC_MAX_DEF,
  parameter int REP_DELAY  = 5000,
  parameter int REP_PERIOD = 1000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       CE,
  input  logic       TICK,
  input  logic       PE,
  input  logic [7:0] D_H,
  input  logic [7:0] D_M,
  input  logic [7:0] D_S,
  input  logic       HU,
  input  logic       HD,
  input  logic       MU,
  input  logic       MD,
  input  logic       SU,
  input  logic       SD,
  output logic [7:0] Q_H,
  output logic [7:0] Q_M,
  output logic [7:0] Q_S,
  output logic       TC_S,
  output logic       TC_M,
  output logic       TC_H,
  output logic       ADJ
);

  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int CNT_W   = $clog2(REP_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_CNT  = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(REP_PERIOD);

  adj_state_e       state_q, state_d;
  field_e           sel_field_q, sel_field_d;
  logic             sel_up_q, sel_up_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             adj_q;
  logic [2:0]       tc_q;

  field_e           req_field;
  logic             req_up;
  logic             sel_held;
  logic             step_en;
  logic             tick_ok;
  logic             do_tick;
  logic             s_tick, m_tick, h_tick;

  logic [2:0]         fld_tick;
  logic [2:0]         fld_step;
  logic [2:0]         fld_inc;
  logic [2:0]         fld_dec;
  logic [2:0]         fld_wrap;
  logic [2:0]         fld_full;
  logic [FIELD_W-1:0] fld_q [3];
  logic [FIELD_W-1:0] fld_d [3];

  assign fld_d[0] = D_S;
  assign fld_d[1] = D_M;
  assign fld_d[2] = D_H;

  // Button request: first field (H, M, S) with any button pressed. Up and
  // down together on that field is a conflict and requests nothing.
  always_comb begin
    req_field = FLD_NONE;
    req_up    = 1'b0;
    if (HU | HD) begin
      if (!(HU & HD)) begin
        req_field = FLD_H;
        req_up    = HU;
      end
    end else if (MU | MD) begin
      if (!(MU & MD)) begin
        req_field = FLD_M;
        req_up    = MU;
      end
    end else if (SU | SD) begin
      if (!(SU & SD)) begin
        req_field = FLD_S;
        req_up    = SU;
      end
    end
  end

  // Level of the button latched when the adjust sequence started.
  always_comb begin
    sel_held = 1'b0;
    case (sel_field_q)
      FLD_H:   sel_held = sel_up_q ? HU : HD;
      FLD_M:   sel_held = sel_up_q ? MU : MD;
      FLD_S:   sel_held = sel_up_q ? SU : SD;
      default: sel_held = 1'b0;
    endcase
  end

  // Adjust FSM. cnt_q counts cycles since the press while in STEP/HOLD and
  // cycles since the last step while in RPT, so the first repeat lands
  // REP_DELAY cycles after the press and later ones every REP_PERIOD.
  always_comb begin
    state_d     = state_q;
    sel_field_d = sel_field_q;
    sel_up_d    = sel_up_q;
    cnt_d       = cnt_q;
    step_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_field != FLD_NONE) begin
          state_d     = ST_STEP;
          sel_field_d = req_field;
          sel_up_d    = req_up;
          cnt_d       = CNT_W'(1);
          step_en     = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = ST_HOLD;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_HOLD: begin
        if (!sel_held) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DELAY_CNT) begin
          state_d = ST_RPT;
          cnt_d   = CNT_W'(1);
          step_en = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RPT: begin
        if (!sel_held) begin
          state_d = ST_IDLE;
        end else if (cnt_q == PERIOD_CNT) begin
          cnt_d   = CNT_W'(1);
          step_en = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick arbitration against preset and steps, plus the pending flag.
  // A seconds step discards any parked tick so the adjusted second holds.
  always_comb begin
    tick_ok = TICK & CE;
    do_tick = 1'b0;
    pend_d  = pend_q;
    if (PE) begin
      pend_d = 1'b0;
    end else if (step_en) begin
      pend_d = (sel_field_d == FLD_S) ? 1'b0 : (pend_q | tick_ok);
    end else begin
      do_tick = tick_ok | (pend_q & CE);
      pend_d  = pend_q & ~CE;
    end
  end

  // Carry ripple from the registered field values, so it never loops
  // through the counters' combinational wrap outputs.
  assign s_tick   = do_tick;
  assign m_tick   = s_tick & fld_full[0];
  assign h_tick   = m_tick & fld_full[1];
  assign fld_tick = {h_tick, m_tick, s_tick};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      localparam int FMAX = (gi == 0) ? SEC_MAX : ((gi == 1) ? MIN_MAX : HOUR_MAX);

      assign fld_step[gi] = step_en & ~PE & (sel_field_d == field_e'(gi));
      assign fld_inc[gi]  = fld_tick[gi] | (fld_step[gi] & sel_up_d);
      assign fld_dec[gi]  = fld_step[gi] & ~sel_up_d;
      assign fld_full[gi] = (fld_q[gi] == to_bcd(FMAX));

      clock_core_adj_bcd_mod_counter #(
        .MAX (FMAX)
      ) u_cnt (
        .clk_i  (CP),
        .srst_i (CR),
        .inc_i  (fld_inc[gi]),
        .dec_i  (fld_dec[gi]),
        .load_i (PE),
        .d_i    (fld_d[gi]),
        .q_o    (fld_q[gi]),
        .wrap_o (fld_wrap[gi])
      );
    end
  endgenerate

  always_ff @(posedge CP) begin
    if (CR) begin
      state_q     <= ST_IDLE;
      sel_field_q <= FLD_NONE;
      sel_up_q    <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      adj_q       <= 1'b0;
      tc_q        <= '0;
    end else begin
      state_q     <= state_d;
      sel_field_q <= sel_field_d;
      sel_up_q    <= sel_up_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      adj_q       <= (state_d != ST_IDLE);
      // Only tick-driven wraps pulse TC; adjust wraps are masked here.
      tc_q        <= fld_tick & fld_wrap;
    end
  end

  assign Q_S  = fld_q[0];
  assign Q_M  = fld_q[1];
  assign Q_H  = fld_q[2];
  assign TC_S = tc_q[0];
  assign TC_M = tc_q[1];
  assign TC_H = tc_q[2];
  assign ADJ  = adj_q;

endmodule
